audio_out_stage: RTL and testbench

Parametrised audio back-end between the core's raw mixer outputs and the HDMI audio packetiser. It does four things:
- generates a sample strobe and a square audio clock for any pixel clock, using a fractional phase accumulator;
- conditions NCH signed channels (shift, saturate, sticky clip flags);
- applies a shift-based volume with click-free ramping and mute;
- holds one sample per strobe.
It replaces the fixed 48 kHz integer divider and the 2-bit, 2-channel volume logic in the video top level.

---
 rtl/audio_pkg.sv | 38 +++
 rtl/audio_rate_gen.sv | 47 ++++
 rtl/audio_out_stage.sv | 122 ++++++++++++
 tb/tb_audio_out_stage.sv | 280 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/audio_pkg.sv
// Shared definitions for the audio output stage: shift/saturate helper and
// volume constants.
package audio_pkg;

  typedef struct packed {
    logic               ovf;
    logic signed [31:0] val;
  } sat_t;

  // Arithmetic right shift followed by clamp to a signed out_w-bit range.
  function automatic sat_t sat_shift(input logic signed [31:0] x,
                                     input int                 shift,
                                     input int                 out_w);
    sat_t               r;
    logic signed [31:0] s;
    logic signed [31:0] pmax;
    logic signed [31:0] nmin;
    s    = x >>> shift;
    pmax = (32'sd1 <<< (out_w - 1)) - 32'sd1;
    nmin = -(32'sd1 <<< (out_w - 1));
    if (s > pmax) begin
      r.ovf = 1'b1;
      r.val = pmax;
    end else if (s < nmin) begin
      r.ovf = 1'b1;
      r.val = nmin;
    end else begin
      r.ovf = 1'b0;
      r.val = s;
    end
    return r;
  endfunction

  function automatic int unity_vol(input int vol_w);
    return (1 << vol_w) - 1;
  endfunction

endpackage

// File: rtl/audio_rate_gen.sv
// Fractional sample-rate generator: a phase accumulator toggles clk_audio and
// pulses sample_strobe on every rising edge of clk_audio.
module audio_rate_gen #(
  parameter int CLK_HZ      = 27000000,
  parameter int SAMPLE_RATE = 48000,
  parameter int ACC_W       = 32
) (
  input  logic clk,
  input  logic resetn,
  output logic clk_audio,
  output logic sample_strobe
);
  localparam logic [ACC_W-1:0] STEP  = ACC_W'(2 * SAMPLE_RATE);
  localparam logic [ACC_W-1:0] LIMIT = ACC_W'(CLK_HZ);

  logic [ACC_W-1:0] acc_r;
  logic [ACC_W-1:0] nxt_s;
  logic             wrap_s;
  logic             clk_audio_r;
  logic             strobe_r;

  // Phase advance and wrap detection
  always_comb begin
    nxt_s  = acc_r + STEP;
    wrap_s = (nxt_s >= LIMIT);
  end

  // Accumulator, audio clock and strobe registers
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      acc_r       <= '0;
      clk_audio_r <= 1'b0;
      strobe_r    <= 1'b0;
    end else if (wrap_s) begin
      acc_r       <= nxt_s - LIMIT;
      clk_audio_r <= ~clk_audio_r;
      strobe_r    <= ~clk_audio_r;
    end else begin
      acc_r    <= nxt_s;
      strobe_r <= 1'b0;
    end
  end

  assign clk_audio     = clk_audio_r;
  assign sample_strobe = strobe_r;

endmodule

// File: rtl/audio_out_stage.sv
// Audio back-end: sample-rate generation, per-channel shift/saturate with sticky
// clip flags, ramped shift volume and strobe-aligned output hold.
module audio_out_stage
  import audio_pkg::*;
#(
  parameter int CLK_HZ      = 27000000,
  parameter int SAMPLE_RATE = 48000,
  parameter int NCH         = 2,
  parameter int IN_W        = 18,
  parameter int OUT_W       = 16,
  parameter int SHIFT       = 2,
  parameter int VOL_W       = 2,
  parameter int RAMP        = 1,
  parameter int ACC_W       = 32
) (
  input  logic                 clk,
  input  logic                 resetn,
  input  logic [NCH*IN_W-1:0]  audio_in,
  input  logic [VOL_W-1:0]     volume,
  input  logic                 mute,
  input  logic                 clip_clear,
  output logic [NCH*OUT_W-1:0] audio_out,
  output logic                 sample_strobe,
  output logic                 clk_audio,
  output logic [NCH-1:0]       clip
);
  localparam logic [VOL_W-1:0] UNITY_V  = VOL_W'(unity_vol(VOL_W));
  localparam logic [VOL_W-1:0] VOL_STEP = VOL_W'(1);

  logic [VOL_W-1:0] vol_eff_r;
  logic [VOL_W-1:0] vol_nxt_s;
  logic [VOL_W-1:0] target_s;

  audio_rate_gen #(
    .CLK_HZ      (CLK_HZ),
    .SAMPLE_RATE (SAMPLE_RATE),
    .ACC_W       (ACC_W)
  ) u_rate_gen (
    .clk           (clk),
    .resetn        (resetn),
    .clk_audio     (clk_audio),
    .sample_strobe (sample_strobe)
  );

  // Effective volume: follow target directly, or step one level per strobe
  always_comb begin
    target_s = mute ? '0 : volume;
    if (RAMP == 0) begin
      vol_nxt_s = target_s;
    end else if (!sample_strobe) begin
      vol_nxt_s = vol_eff_r;
    end else if (vol_eff_r < target_s) begin
      vol_nxt_s = vol_eff_r + VOL_STEP;
    end else if (vol_eff_r > target_s) begin
      vol_nxt_s = vol_eff_r - VOL_STEP;
    end else begin
      vol_nxt_s = vol_eff_r;
    end
  end

  // Effective volume register
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      vol_eff_r <= '0;
    end else begin
      vol_eff_r <= vol_nxt_s;
    end
  end

  for (genvar ch = 0; ch < NCH; ch++) begin : g_ch
    logic signed [IN_W-1:0]  in_s;
    sat_t                    sat_s;
    logic signed [OUT_W-1:0] s1_r;
    logic signed [OUT_W-1:0] s2_r;
    logic signed [OUT_W-1:0] s2_nxt_s;
    logic signed [OUT_W-1:0] out_r;
    logic                    clip_r;
    logic                    unused_sat_s;

    assign in_s         = audio_in[ch*IN_W +: IN_W];
    assign sat_s        = sat_shift(32'(in_s), SHIFT, OUT_W);
    assign unused_sat_s = ^sat_s.val[31:OUT_W];

    // Volume attenuation; negative samples floor toward -1 at deep attenuation
    always_comb begin
      if (vol_eff_r == '0) begin
        s2_nxt_s = '0;
      end else begin
        s2_nxt_s = s1_r >>> (UNITY_V - vol_eff_r);
      end
    end

    // Condition/volume pipeline, strobe hold and sticky clip (set beats clear)
    always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
        s1_r   <= '0;
        s2_r   <= '0;
        out_r  <= '0;
        clip_r <= 1'b0;
      end else begin
        s1_r <= sat_s.val[OUT_W-1:0];
        s2_r <= s2_nxt_s;
        if (sample_strobe) begin
          out_r <= s2_r;
        end else begin
          out_r <= out_r;
        end
        if (sat_s.ovf) begin
          clip_r <= 1'b1;
        end else if (clip_clear) begin
          clip_r <= 1'b0;
        end else begin
          clip_r <= clip_r;
        end
      end
    end

    assign audio_out[ch*OUT_W +: OUT_W] = out_r;
    assign clip[ch]                     = clip_r;
  end

endmodule

// File: tb/tb_audio_out_stage.sv
// Scoreboard bench: two configurations (SHIFT=2/RAMP=1 and SHIFT=0/RAMP=0) share
// one stimulus stream; an arithmetic reference model predicts each held sample.
module tb_audio_out_stage;
  localparam int  CLK_HZ  = 27000000;
  localparam int  SR      = 48000;
  localparam int  NSTEPS  = 36;
  localparam int  NDIR    = 12;
  localparam int  RST_AT  = 24;
  localparam int  SHIFT_A = 2;
  localparam int  SHIFT_B = 0;

  typedef struct packed {
    logic [17:0] in1;
    logic [17:0] in0;
    logic [1:0]  vol;
    logic        mute;
    logic        clr;
  } step_t;

  typedef struct packed {
    logic [31:0] aout;
    logic [1:0]  clip;
  } exp_t;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic [35:0] audio_in = '0;
  logic [1:0]  volume = '0;
  logic        mute = 1'b0;
  logic        clip_clear = 1'b0;
  logic [31:0] aout_a, aout_b;
  logic        strobe_a, strobe_b, clka_a, clka_b;
  logic [1:0]  clip_a, clip_b;

  int    checks = 0;
  int    failures = 0;
  exp_t  q_a[$];
  exp_t  q_b[$];
  step_t cur;
  step_t dir[NDIR];
  int    vol_ramp;
  logic [1:0] clip_m_a, clip_m_b;

  always #5 clk = ~clk;

  audio_out_stage #(.CLK_HZ(CLK_HZ), .SAMPLE_RATE(SR), .NCH(2), .IN_W(18), .OUT_W(16),
                    .SHIFT(SHIFT_A), .VOL_W(2), .RAMP(1), .ACC_W(32)) dut_a (
    .clk(clk), .resetn(resetn), .audio_in(audio_in), .volume(volume), .mute(mute),
    .clip_clear(clip_clear), .audio_out(aout_a), .sample_strobe(strobe_a),
    .clk_audio(clka_a), .clip(clip_a));

  audio_out_stage #(.CLK_HZ(CLK_HZ), .SAMPLE_RATE(SR), .NCH(2), .IN_W(18), .OUT_W(16),
                    .SHIFT(SHIFT_B), .VOL_W(2), .RAMP(0), .ACC_W(32)) dut_b (
    .clk(clk), .resetn(resetn), .audio_in(audio_in), .volume(volume), .mute(mute),
    .clip_clear(clip_clear), .audio_out(aout_b), .sample_strobe(strobe_b),
    .clk_audio(clka_b), .clip(clip_b));

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Floor division (rounds toward minus infinity)
  function automatic int fdiv(input int x, input int d);
    if (x >= 0) return x / d;
    else return -((-x + d - 1) / d);
  endfunction

  function automatic void model_ch(input logic [17:0] raw, input int shift, input int vol,
                                   output logic [15:0] y, output logic ovf);
    int x;
    int s;
    x = int'(raw);
    if (raw[17]) x = x - 262144;
    s   = fdiv(x, 1 << shift);
    ovf = 1'b0;
    if (s > 32767) begin
      s = 32767; ovf = 1'b1;
    end else if (s < -32768) begin
      s = -32768; ovf = 1'b1;
    end
    if (vol == 0) s = 0;
    else s = fdiv(s, 1 << (3 - vol));
    y = 16'(s);
  endfunction

  function automatic void model_out(input step_t st, input int shift, input int vol,
                                    output logic [31:0] y, output logic [1:0] ovf);
    logic [15:0] y0, y1;
    logic        o0, o1;
    model_ch(st.in0, shift, vol, y0, o0);
    model_ch(st.in1, shift, vol, y1, o1);
    y   = {y1, y0};
    ovf = {o1, o0};
  endfunction

  function automatic int target_of(input step_t st);
    return st.mute ? 0 : int'(st.vol);
  endfunction

  function automatic step_t mk(input logic [17:0] in1, input logic [17:0] in0,
                               input logic [1:0] vol, input logic mu, input logic clr);
    step_t s;
    s.in1 = in1; s.in0 = in0; s.vol = vol; s.mute = mu; s.clr = clr;
    return s;
  endfunction

  function automatic logic [17:0] pick18();
    case ($urandom_range(0, 3))
      0:       return 18'h1FFFF;
      1:       return 18'h20000;
      default: return 18'($urandom);
    endcase
  endfunction

  function automatic step_t rand_step();
    return mk(pick18(), pick18(), 2'($urandom), ($urandom_range(0, 7) == 0),
              ($urandom_range(0, 3) == 0));
  endfunction

  task automatic drive(input step_t st);
    audio_in   = {st.in1, st.in0};
    volume     = st.vol;
    mute       = st.mute;
    clip_clear = st.clr;
  endtask

  task automatic model_reset();
    logic [31:0] dummy;
    vol_ramp = 0;
    model_out(cur, SHIFT_A, 0, dummy, clip_m_a);
    model_out(cur, SHIFT_B, 0, dummy, clip_m_b);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, " audio_out_a"}, aout_a, 0);
    check({tag, " audio_out_b"}, aout_b, 0);
    check({tag, " strobe"}, {strobe_a, strobe_b}, 0);
    check({tag, " clk_audio"}, {clka_a, clka_b}, 0);
    check({tag, " clip_a"}, clip_a, 0);
    check({tag, " clip_b"}, clip_b, 0);
  endtask

  task automatic wait_strobe(output bit ok);
    ok = 1'b0;
    for (int n = 0; n < 700; n++) begin
      @(negedge clk);
      if (strobe_a) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  // Strobe/clk_audio timing: toggle count after t cycles is floor(t*2*SR/CLK_HZ)
  longint t = 0;
  int     sc = 0;
  always @(posedge clk) begin
    longint k;
    longint kp;
    #1;
    if (!resetn) begin
      t  = 0;
      sc = 0;
      check("strobe during reset", {strobe_a, strobe_b}, 0);
    end else begin
      t++;
      k  = (t * 2 * SR) / CLK_HZ;
      kp = ((t - 1) * 2 * SR) / CLK_HZ;
      check("strobe_a timing", strobe_a, (k != kp) && k[0]);
      check("strobe_b timing", strobe_b, (k != kp) && k[0]);
      check("clk_audio_a level", clka_a, k[0]);
      check("clk_audio_b level", clka_b, k[0]);
      sc += int'(strobe_a);
      if (t == 5625) check("strobe count in 5625 cycles", sc, 10);
    end
  end

  // Monitor: one cycle after each DUT strobe the held sample must match the queue head
  bit pend_a = 1'b0;
  bit pend_b = 1'b0;
  always @(negedge clk) begin
    exp_t e;
    if (pend_a) begin
      if (q_a.size() == 0) begin
        checks++; failures++;
        $display("FAIL scoreboard_a: output with no expected entry at %0t", $time);
      end else begin
        e = q_a.pop_front();
        check("audio_out_a", aout_a, e.aout);
        check("clip_a", clip_a, e.clip);
      end
    end
    if (pend_b) begin
      if (q_b.size() == 0) begin
        checks++; failures++;
        $display("FAIL scoreboard_b: output with no expected entry at %0t", $time);
      end else begin
        e = q_b.pop_front();
        check("audio_out_b", aout_b, e.aout);
        check("clip_b", clip_b, e.clip);
      end
    end
    pend_a = resetn && strobe_a;
    pend_b = resetn && strobe_b;
  end

  initial begin
    step_t       nxt;
    logic [31:0] ya, yb, dummy;
    logic [1:0]  oa, ob, na, nb;
    bit          ok;

    dir[0]  = mk(18'h1FFFF, 18'h10000, 2'd3, 1'b0, 1'b0);
    dir[1]  = dir[0];
    dir[2]  = dir[0];
    dir[3]  = mk(18'h1FFFF, 18'h10000, 2'd0, 1'b0, 1'b0);
    dir[4]  = dir[3];
    dir[5]  = dir[0];
    dir[6]  = dir[0];
    dir[7]  = mk(18'h20000, 18'h3FFFC, 2'd1, 1'b0, 1'b0);
    dir[8]  = mk(18'h20000, 18'h3FFFC, 2'd1, 1'b0, 1'b1);
    dir[9]  = mk(18'h00005, 18'h3FFFC, 2'd1, 1'b0, 1'b1);
    dir[10] = mk(18'h00000, 18'h10000, 2'd3, 1'b1, 1'b0);
    dir[11] = mk(18'h00000, 18'h10000, 2'd2, 1'b0, 1'b0);

    cur = dir[0];
    drive(cur);
    resetn = 1'b0;
    repeat (3) @(negedge clk);
    check_all_zero("reset");
    resetn = 1'b1;
    model_reset();

    for (int i = 0; i < NSTEPS; i++) begin
      wait_strobe(ok);
      if (!ok) begin
        checks++; failures++;
        $display("FAIL strobe_timeout: no sample_strobe within 700 cycles at step %0d", i);
        break;
      end
      model_out(cur, SHIFT_A, vol_ramp, ya, oa);
      model_out(cur, SHIFT_B, target_of(cur), yb, ob);
      nxt = (i < NDIR) ? dir[i] : rand_step();
      drive(nxt);
      cur = nxt;
      if (vol_ramp < target_of(cur)) vol_ramp++;
      else if (vol_ramp > target_of(cur)) vol_ramp--;
      model_out(cur, SHIFT_A, 0, dummy, na);
      model_out(cur, SHIFT_B, 0, dummy, nb);
      clip_m_a = cur.clr ? na : (clip_m_a | na);
      clip_m_b = cur.clr ? nb : (clip_m_b | nb);
      q_a.push_back('{aout: ya, clip: clip_m_a});
      q_b.push_back('{aout: yb, clip: clip_m_b});
      if (cur.clr) begin
        @(negedge clk);
        clip_clear = 1'b0;
      end
      if (i == RST_AT) begin
        repeat (100) @(negedge clk);
        resetn = 1'b0;
        #1;
        check_all_zero("mid-run reset");
        repeat (3) @(negedge clk);
        resetn = 1'b1;
        model_reset();
      end
    end

    repeat (3) @(negedge clk);
    check("scoreboard_a drained", q_a.size(), 0);
    check("scoreboard_b drained", q_b.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
